// File: rtl/mem_access_pkg.sv
// Shared constants and FSM encoding for the load/store initiator.
package mem_access_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int BYTE_OFF_W = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    RESP  = ST_RESP
  } state_e;

endpackage

// File: rtl/mem_ea_check.sv
// Effective-address adder plus range/alignment fault detection (combinational).
// Alignment faults are reported only when MEM_ACCESS_CTRL_ALIGN_CHECK_EN is defined.
module mem_ea_check
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] ea,
  output logic [ADDR_W-1:0] idx,
  output logic              range_fault,
  output logic              align_fault
);

  // Carry out of the add is dropped, so wrapped addresses can land in range.
  assign ea          = op1 + op2;
  assign idx         = ea[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign range_fault = |ea[DATA_W-1:ADDR_W+BYTE_OFF_W];

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
  assign align_fault = |ea[BYTE_OFF_W-1:0];
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the 8-word data memory.
// Optional alignment fault: define MEM_ACCESS_CTRL_ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e            state, state_nxt;
  logic [DATA_W-1:0] op1_q, op2_q, wdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] idx, idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] ea_unused;
  logic              range_fault, align_fault, fault, acc;

  mem_ea_check #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ea (
    .op1         (op1_q),
    .op2         (op2_q),
    .ea          (ea_unused),
    .idx         (idx),
    .range_fault (range_fault),
    .align_fault (align_fault)
  );

  assign fault     = range_fault | align_fault;
  assign req_ready = (state == IDLE) && !rst;
  assign acc       = req_valid && req_ready;

  // Strobes decode straight from state so a reset clears them on the next cycle.
  assign mem_wr_en  = (state == WRITE);
  assign mem_rd_en  = (state == READ);
  assign mem_add    = (mem_wr_en || mem_rd_en) ? idx_q : '0;
  assign mem_data   = mem_wr_en ? wdata_q : '0;
  assign resp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = ADDR;
      ADDR:    state_nxt = fault ? RESP : (we_q ? WRITE : READ);
      WRITE:   state_nxt = RESP;
      READ:    if (cnt_q == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (acc) begin
          op1_q   <= req_op1;
          op2_q   <= req_op2;
          wdata_q <= req_wdata;
          we_q    <= req_we;
        end
        ADDR: begin
          idx_q      <= idx;
          resp_err   <= fault;
          resp_rdata <= '0;
          cnt_q      <= CNT_W'(RD_LAT - 1);
        end
        READ: begin
          if (cnt_q == '0) resp_rdata <= mem_rd_data;
          else             cnt_q      <= cnt_q - 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural 8-word memory.
module tb_mem_access_ctrl;

  localparam int DW     = 32;
  localparam int AW     = 3;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [DW-1:0] req_op1 = '0, req_op2 = '0, req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_wr_en, mem_rd_en;
  logic [DW-1:0] resp_rdata, mem_data, mem_rd_data;
  logic [AW-1:0] mem_add;

  logic [DW-1:0] mem     [8] = '{default: '0};
  logic [DW-1:0] ref_mem [8] = '{default: '0};

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    logic [AW-1:0] idx;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_add     (mem_add),
    .mem_data    (mem_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data)
  );

  always @(posedge clk) if (mem_wr_en) mem[mem_add] <= mem_data;
  assign mem_rd_data = mem[mem_add];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_wr"},    32'(mem_wr_en),  32'd0);
    chk({tag, "_rd"},    32'(mem_rd_en),  32'd0);
    chk({tag, "_add"},   32'(mem_add),    32'd0);
    chk({tag, "_data"},  mem_data,        32'd0);
    chk({tag, "_rvld"},  32'(resp_valid), 32'd0);
    chk({tag, "_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_err"},   32'(resp_err),   32'd0);
  endtask

  // Drive one request, predict its response, then follow it cycle by cycle.
  task automatic txn(input logic we, input logic [31:0] op1, input logic [31:0] op2,
                     input logic [31:0] wd, input int hold, input logic early);
    exp_t          e, got;
    logic [31:0]   ea;
    logic          flt;
    int            cyc, wr_n, rd_n;
    ea  = op1 + op2;
    flt = |ea[31:5];
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    flt = flt | (|ea[1:0]);
`endif
    e.idx   = ea[4:2];
    e.err   = flt;
    e.rdata = (we || flt) ? 32'd0 : ref_mem[e.idx];
    e.lat   = flt ? 2 : (we ? 3 : 2 + RD_LAT);
    if (we && !flt) ref_mem[e.idx] = wd;
    exp_q.push_back(e);

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_op1 = op1; req_op2 = op2; req_wdata = wd;
    resp_ready = early;
    @(posedge clk); #1;
    req_valid = 1'b0;

    cyc = 0; wr_n = 0; rd_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      chk("strobe_excl", 32'(mem_wr_en & mem_rd_en), 32'd0);
      if (mem_wr_en) begin
        wr_n++;
        chk("wr_add", 32'(mem_add), 32'(e.idx));
        chk("wr_data", mem_data, wd);
      end
      if (mem_rd_en) begin
        rd_n++;
        chk("rd_add", 32'(mem_add), 32'(e.idx));
      end
      if (!resp_valid) chk("req_ready_busy", 32'(req_ready), 32'd0);
    end while (!resp_valid && cyc < 40);

    chk("resp_lat", 32'(cyc), 32'(e.lat));
    chk("wr_pulses", 32'(wr_n), (we && !flt) ? 32'd1 : 32'd0);
    chk("rd_cycles", 32'(rd_n), (!we && !flt) ? 32'(RD_LAT) : 32'd0);

    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'(exp_q.size()), 32'd1);
      got = e;
    end else got = exp_q.pop_front();
    chk("resp_rdata", resp_rdata, got.rdata);
    chk("resp_err", 32'(resp_err), 32'(got.err));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, got.rdata);
      chk("bp_err", 32'(resp_err), 32'(got.err));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", 32'(resp_valid), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with a request pending: nothing accepted, outputs at reset values.
    rst = 1'b1; req_valid = 1'b1; req_op1 = 32'd4;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk_idle_outs("rst");
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk_idle_outs("rel");

    for (int k = 0; k < 8; k++)
      txn(1'b1, 32'd4, 32'(4 * k - 4), 32'(k), 0, k[0]);
    for (int k = 0; k < 8; k++)
      txn(1'b0, 32'd4, 32'(4 * k - 4), 32'd0, (k == 2) ? 5 : 0, k == 3);

    txn(1'b0, 32'h20, 32'd0, 32'd0, 0, 1'b0);          // range fault, load
    txn(1'b1, 32'h100, 32'd4, 32'hDEAD, 0, 1'b0);      // range fault, store
    txn(1'b0, 32'd5, 32'd0, 32'd0, 0, 1'b0);           // misaligned
    txn(1'b1, 32'hFFFF_FFFC, 32'd8, 32'hA5A5, 0, 1'b0); // wraps to 4
    txn(1'b0, 32'd4, 32'd0, 32'd0, 3, 1'b0);
    txn(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 0, 1'b0); // wraps high: fault

    // Reset in the second READ cycle abandons the load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_op1 = 32'd8; req_op2 = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rd1", 32'(mem_rd_en), 32'd1);
    @(negedge clk);
    chk("mid_rd2", 32'(mem_rd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd", 32'(mem_rd_en), 32'd0);
    chk("mid_rst_vld", 32'(resp_valid), 32'd0);
    chk("mid_rst_rdy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      @(negedge clk);
      chk("mid_post_vld", 32'(resp_valid), 32'd0);
      chk("mid_post_rdy", 32'(req_ready), 32'd1);
    end
    txn(1'b0, 32'd8, 32'd0, 32'd0, 0, 1'b0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
